// File: rtl/memory_wrapper_burst_pkg.sv
// Shared definitions for the burst memory wrapper: bank state encoding,
// read-latency bounds and port-slicing helpers.
package memory_wrapper_burst_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BURST = 2'd1,
      ST_DONE  = 2'd2
   } bank_state_e;

   localparam int READ_LATENCY_MIN = 1;
   localparam int READ_LATENCY_MAX = 3;

   // Clamp a requested read latency into the supported range.
   function automatic int clamp_latency(input int lat);
      if (lat < READ_LATENCY_MIN) begin
         return READ_LATENCY_MIN;
      end else if (lat > READ_LATENCY_MAX) begin
         return READ_LATENCY_MAX;
      end else begin
         return lat;
      end
   endfunction

   // Low bit of bank idx within the packed address bus.
   function automatic int addr_lo(input int idx, input int addr_size);
      return idx * addr_size;
   endfunction

   // Low bit of bank idx within the packed length bus.
   function automatic int len_lo(input int idx, input int len_w);
      return idx * len_w;
   endfunction

   // Low bit of bank idx within the packed data buses.
   function automatic int data_lo(input int idx, input int width);
      return idx * width;
   endfunction

endpackage

// File: rtl/memory_wrapper_burst_bank.sv
// One independent single-port bank: burst FSM, address/beat counter,
// storage array and a fixed-latency read delay line.
module mem_bank_burst
   import memory_wrapper_burst_pkg::*;
#(
   parameter int DEPTH        = 512,
   parameter int WIDTH        = 16,
   parameter int ADDR_SIZE    = 9,
   parameter int LEN_W        = 9,
   parameter int READ_LATENCY = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 valid_i,
   output logic                 ready_o,
   input  logic                 wr_rd_i,
   input  logic [ADDR_SIZE-1:0] addr_i,
   input  logic [LEN_W-1:0]     len_i,
   input  logic [WIDTH-1:0]     wdata_i,
   output logic [WIDTH-1:0]     rdata_o,
   output logic                 rvalid_o,
   output logic                 done_o,
   output logic                 err_o
);

   localparam int RL = clamp_latency(READ_LATENCY);
   localparam logic [ADDR_SIZE:0] DEPTH_W = (ADDR_SIZE+1)'(DEPTH);

   bank_state_e          state_q, state_d;
   logic                 ready_q, ready_d;
   logic                 wr_q, wr_d;
   logic [ADDR_SIZE-1:0] cur_addr_q, cur_addr_d;
   logic [LEN_W-1:0]     remaining_q, remaining_d;

   logic                 fire_s;
   logic                 acc_en_s;
   logic                 acc_wr_s;
   logic [ADDR_SIZE-1:0] acc_addr_s;
   logic                 done_s;
   logic                 err_s;

   logic [WIDTH-1:0]     mem_q [DEPTH];
   logic [RL-1:0]        pv_q;
   logic [WIDTH-1:0]     pd_q [RL];

   // Next sequential address, wrapping from DEPTH-1 back to zero.
   function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
      logic [ADDR_SIZE:0] inc;
      inc = {1'b0, a} + {{ADDR_SIZE{1'b0}}, 1'b1};
      if (inc == DEPTH_W) begin
         return {ADDR_SIZE{1'b0}};
      end else begin
         return inc[ADDR_SIZE-1:0];
      end
   endfunction

   // Burst FSM: decide the access for this cycle and the next bank state.
   always_comb begin
      state_d     = state_q;
      wr_d        = wr_q;
      cur_addr_d  = cur_addr_q;
      remaining_d = remaining_q;
      acc_en_s    = 1'b0;
      acc_wr_s    = 1'b0;
      acc_addr_s  = cur_addr_q;
      done_s      = 1'b0;
      err_s       = 1'b0;
      fire_s      = valid_i & ready_q;
      case (state_q)
         ST_IDLE: begin
            if (fire_s) begin
               if ({1'b0, addr_i} >= DEPTH_W) begin
                  err_s = 1'b1;
               end else begin
                  acc_en_s    = 1'b1;
                  acc_wr_s    = wr_rd_i;
                  acc_addr_s  = addr_i;
                  wr_d        = wr_rd_i;
                  cur_addr_d  = next_addr(addr_i);
                  remaining_d = len_i;
                  if (len_i == {LEN_W{1'b0}}) begin
                     done_s  = 1'b1;
                     state_d = ST_DONE;
                  end else begin
                     state_d = ST_BURST;
                  end
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BURST: begin
            if (fire_s) begin
               acc_en_s    = 1'b1;
               acc_wr_s    = wr_q;
               acc_addr_s  = cur_addr_q;
               cur_addr_d  = next_addr(cur_addr_q);
               remaining_d = remaining_q - LEN_W'(1);
               if (remaining_q == LEN_W'(1)) begin
                  done_s  = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_BURST;
               end
            end else begin
               state_d = ST_BURST;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      ready_d = (state_d != ST_DONE);
   end

   // Control registers; ready stays low in reset and rises on the first edge after.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         ready_q     <= 1'b0;
         wr_q        <= 1'b0;
         cur_addr_q  <= {ADDR_SIZE{1'b0}};
         remaining_q <= {LEN_W{1'b0}};
      end else begin
         state_q     <= state_d;
         ready_q     <= ready_d;
         wr_q        <= wr_d;
         cur_addr_q  <= cur_addr_d;
         remaining_q <= remaining_d;
      end
   end

   // Storage array; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (acc_en_s && acc_wr_s) begin
         mem_q[acc_addr_s] <= wdata_i;
      end
   end

   // Read delay line: synchronous array read, then RL-1 further stages.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pv_q <= {RL{1'b0}};
         for (int k = 0; k < RL; k++) begin
            pd_q[k] <= {WIDTH{1'b0}};
         end
      end else begin
         pv_q[0] <= acc_en_s & ~acc_wr_s;
         if (acc_en_s && !acc_wr_s) begin
            pd_q[0] <= mem_q[acc_addr_s];
         end
         for (int k = 1; k < RL; k++) begin
            pv_q[k] <= pv_q[k-1];
            pd_q[k] <= pd_q[k-1];
         end
      end
   end

   assign ready_o  = ready_q;
   assign rvalid_o = pv_q[RL-1];
   assign rdata_o  = pd_q[RL-1];
   assign done_o   = done_s;
   assign err_o    = err_s;

endmodule

// File: rtl/memory_wrapper_burst.sv
// Top: NUM_MEMS independent burst banks; only slices and concatenates ports.
module memory_wrapper_burst
   import memory_wrapper_burst_pkg::*;
#(
   parameter int NUM_MEMS     = 4,
   parameter int DEPTH        = 512,
   parameter int WIDTH        = 16,
   parameter int ADDR_SIZE    = 9,
   parameter int LEN_W        = 9,
   parameter int READ_LATENCY = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_MEMS-1:0]           valid,
   output logic [NUM_MEMS-1:0]           ready,
   input  logic [NUM_MEMS-1:0]           wr_rd,
   input  logic [NUM_MEMS*ADDR_SIZE-1:0] addr,
   input  logic [NUM_MEMS*LEN_W-1:0]     len,
   input  logic [NUM_MEMS*WIDTH-1:0]     wdata,
   output logic [NUM_MEMS*WIDTH-1:0]     rdata,
   output logic [NUM_MEMS-1:0]           rvalid,
   output logic [NUM_MEMS-1:0]           done,
   output logic [NUM_MEMS-1:0]           err
);

   for (genvar i = 0; i < NUM_MEMS; i++) begin : g_bank
      mem_bank_burst #(
         .DEPTH        (DEPTH),
         .WIDTH        (WIDTH),
         .ADDR_SIZE    (ADDR_SIZE),
         .LEN_W        (LEN_W),
         .READ_LATENCY (READ_LATENCY)
      ) u_bank (
         .clk      (clk),
         .rst      (rst),
         .valid_i  (valid[i]),
         .ready_o  (ready[i]),
         .wr_rd_i  (wr_rd[i]),
         .addr_i   (addr[addr_lo(i, ADDR_SIZE) +: ADDR_SIZE]),
         .len_i    (len[len_lo(i, LEN_W) +: LEN_W]),
         .wdata_i  (wdata[data_lo(i, WIDTH) +: WIDTH]),
         .rdata_o  (rdata[data_lo(i, WIDTH) +: WIDTH]),
         .rvalid_o (rvalid[i]),
         .done_o   (done[i]),
         .err_o    (err[i])
      );
   end

endmodule
